// File: rtl/brownout_detector_if.sv
// Supply-monitor bus: ADC sample, thresholds and rate limit in, brownout flag out.
interface brownout_detector_if #(
   parameter int ADC_W  = 20,
   parameter int RATE_W = 12
) ();
   logic [ADC_W-1:0]  ADC_IN;
   logic [ADC_W-1:0]  BOD_THRESH1;
   logic [ADC_W-1:0]  BOD_THRESH2;
   logic [RATE_W-1:0] RATE_LIMIT;
   logic              BROWNOUT;

   modport master (
      output ADC_IN, BOD_THRESH1, BOD_THRESH2, RATE_LIMIT,
      input  BROWNOUT
   );

   modport slave (
      input  ADC_IN, BOD_THRESH1, BOD_THRESH2, RATE_LIMIT,
      output BROWNOUT
   );
endinterface

// File: rtl/brownout_detector.sv
// Brownout detector: trips on a hard undervoltage or a too-fast fall inside the
// warning window, and releases only after RELEASE_CNT consecutive healthy samples.
module brownout_detector #(
   parameter int ADC_W       = 20,
   parameter int RATE_W      = 12,
   parameter int RELEASE_CNT = 4
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   brownout_detector_if.slave   bus
);
   localparam int CNT_W = $clog2(RELEASE_CNT + 1);

   logic [ADC_W-1:0] prev_q, prev_d;
   logic             prev_valid_q, prev_valid_d;
   logic             brownout_q, brownout_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             hard_trip;
   logic             in_window;
   logic             rate_trip;
   logic [ADC_W-1:0] drop;

   assign hard_trip = bus.ADC_IN < bus.BOD_THRESH2;
   assign in_window = bus.ADC_IN < bus.BOD_THRESH1;
   assign drop      = (prev_valid_q && (prev_q > bus.ADC_IN)) ? (prev_q - bus.ADC_IN) : '0;
   assign rate_trip = in_window && (drop > ADC_W'(bus.RATE_LIMIT));

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
      prev_d       = bus.ADC_IN;
      prev_valid_d = 1'b1;
      brownout_d   = brownout_q;
      cnt_d        = '0;

      if (hard_trip || rate_trip) begin
         brownout_d = 1'b1;
      end else if (brownout_q && !in_window) begin
         // Release on the sample that completes the healthy run; saturate otherwise.
         if (cnt_q == CNT_W'(RELEASE_CNT - 1)) begin
            brownout_d = 1'b0;
         end else if (cnt_q < CNT_W'(RELEASE_CNT)) begin
            cnt_d = cnt_q + 1'b1;
         end else begin
            cnt_d = cnt_q;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         prev_q       <= '0;
         prev_valid_q <= 1'b0;
         brownout_q   <= 1'b0;
         cnt_q        <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so all registers update together.
         prev_q       <= prev_d;
         prev_valid_q <= prev_valid_d;
         brownout_q   <= brownout_d;
         cnt_q        <= cnt_d;
      end
   end

   assign bus.BROWNOUT = brownout_q;
endmodule

// File: tb/tb_brownout_detector.sv
// Directed-vector bench for brownout_detector: stimulus pushes expected flags into a
// scoreboard queue, a monitor pops and compares one edge later.
module tb_brownout_detector;
   logic CLK;
   logic RST_N;

   brownout_detector_if #(.ADC_W(20), .RATE_W(12)) bus ();

   brownout_detector #(.ADC_W(20), .RATE_W(12), .RELEASE_CNT(4)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   typedef struct {
      string name;
      logic  exp;
   } sb_entry_t;

   sb_entry_t sb[$];
   int total = 0;
   int bad   = 0;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called at a negedge: presents a sample for the next rising edge and returns at the following negedge.
   task automatic drive(input string name, input logic [19:0] adc, input logic exp);
      sb_entry_t e;
      bus.ADC_IN = adc;
      e.name = name;
      e.exp  = exp;
      sb.push_back(e);
      @(negedge CLK);
   endtask

   task automatic reset_pulse(input string name);
      #2 RST_N = 1'b0;
      #1 check(name, bus.BROWNOUT, 1'b0);
      @(negedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
   endtask

   always @(posedge CLK) begin
      sb_entry_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check(e.name, bus.BROWNOUT, e.exp);
      end
   end

   initial begin
      RST_N           = 1'b0;
      bus.ADC_IN      = 20'h00000;
      bus.BOD_THRESH1 = 20'hE38E4;
      bus.BOD_THRESH2 = 20'hD5555;
      bus.RATE_LIMIT  = 12'h00C;

      // 1. reset state, healthy input and large drops above the window
      repeat (2) @(negedge CLK);
      check("reset_state", bus.BROWNOUT, 1'b0);
      reset_pulse("reset_midcycle");
      drive("healthy_fff0", 20'hFFFF0, 1'b0);
      drive("above_win_drop", 20'hF0000, 1'b0);

      // 2. slow in-window decline, then a fast one
      drive("at_thresh1", 20'hE38E4, 1'b0);
      drive("drop_1", 20'hE38E3, 1'b0);
      drive("drop_3", 20'hE38E0, 1'b0);
      drive("drop_3c", 20'hE38A4, 1'b1);

      // 3. rate boundary; release first, then place PREV=E3800 with the limit opened
      drive("rel_a1", 20'hE38E4, 1'b1);
      drive("rel_a2", 20'hE38E4, 1'b1);
      drive("rel_a3", 20'hE38E4, 1'b1);
      drive("rel_a4", 20'hE38E4, 1'b0);
      bus.RATE_LIMIT = 12'hFFF;
      drive("set_prev_1", 20'hE3800, 1'b0);
      bus.RATE_LIMIT = 12'h00C;
      drive("drop_eq_limit", 20'hE37F4, 1'b0);
      bus.RATE_LIMIT = 12'hFFF;
      drive("set_prev_2", 20'hE3800, 1'b0);
      bus.RATE_LIMIT = 12'h00C;
      drive("drop_limit_p1", 20'hE37F3, 1'b1);
      drive("rel_b1", 20'hE38E4, 1'b1);
      drive("rel_b2", 20'hE38E4, 1'b1);
      drive("rel_b3", 20'hE38E4, 1'b1);
      drive("rel_b4", 20'hE38E4, 1'b0);
      drive("rise_e3920", 20'hE3920, 1'b0);
      drive("drop20_above", 20'hE3900, 1'b0);

      // 4. hard threshold boundary in steps of 1, rate checking neutralised
      bus.RATE_LIMIT = 12'hFFF;
      reset_pulse("reset_pre_hard");
      drive("first_d5556", 20'hD5556, 1'b0);
      drive("eq_thresh2", 20'hD5555, 1'b0);
      drive("below_thresh2", 20'hD5554, 1'b1);

      // 5. release hysteresis, then a restart of the healthy run
      bus.RATE_LIMIT = 12'h00C;
      drive("hyst_1", 20'hE38E4, 1'b1);
      drive("hyst_2", 20'hE38E4, 1'b1);
      drive("hyst_3", 20'hE38E4, 1'b1);
      drive("hyst_4", 20'hE38E4, 1'b0);
      drive("retrip_hard", 20'hD5554, 1'b1);
      drive("restart_1", 20'hE38E4, 1'b1);
      drive("restart_2", 20'hE38E4, 1'b1);
      drive("restart_dip", 20'hE38E3, 1'b1);
      drive("restart_r1", 20'hE38E4, 1'b1);
      drive("restart_r2", 20'hE38E4, 1'b1);
      drive("restart_r3", 20'hE38E4, 1'b1);
      drive("restart_r4", 20'hE38E4, 1'b0);

      // 6. simultaneous trips, reset while tripped, first-sample behaviour
      drive("hard_and_rate", 20'hD0000, 1'b1);
      drive("tripped_hi", 20'hE38E4, 1'b1);
      reset_pulse("reset_while_tripped");
      drive("post_rst_e3800", 20'hE3800, 1'b0);
      drive("healthy_again", 20'hFFFF0, 1'b0);
      reset_pulse("reset_before_first");
      drive("first_e38e0", 20'hE38E0, 1'b0);
      drive("second_drop10", 20'hE38D0, 1'b1);

      repeat (2) @(negedge CLK);
      check("scoreboard_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end
endmodule

// File: doc/brownout_detector.md
Name: brownout_detector

Overview:
- Supply-monitor block. Watches a 20-bit ADC sample stream of the supply rail and raises BROWNOUT when the rail falls below a hard threshold.
- It also raises BROWNOUT when the rail is inside a warning window and falls faster than a programmable per-sample rate.
- It sits between the supply ADC front end and the reset/power-management controller.
- BROWNOUT is registered and clears only after a hysteresis period of healthy samples.

Parameters:
- ADC_W, 20, width of ADC_IN, BOD_THRESH1 and BOD_THRESH2.
- RATE_W, 12, width of RATE_LIMIT.
- RELEASE_CNT, 4, number of consecutive healthy samples (ADC_IN >= BOD_THRESH1) required to deassert BROWNOUT.

Ports:
- CLK  in  1  system clock; every rising edge is one ADC sample.
- RST_N  in  1  asynchronous active-low reset.
- ADC_IN  in  ADC_W  current supply sample, unsigned.
- BOD_THRESH1  in  ADC_W  warning threshold (upper); rate checking is enabled only below it.
- BOD_THRESH2  in  ADC_W  hard trip threshold (lower).
- RATE_LIMIT  in  RATE_W  maximum allowed per-sample drop inside the warning window, unsigned.
- BROWNOUT  out  1  registered brownout flag, active high.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - BROWNOUT=0.
  - PREV (previous-sample register) = 0.
  - PREV_VALID=0.
  - Release counter = 0.
- Every rising edge with RST_N=1 does the following; all comparisons are unsigned and combinational on the current ADC_IN.
  - hard_trip = ADC_IN < BOD_THRESH2. Equality does not trip.
  - in_window = ADC_IN < BOD_THRESH1. Equality is healthy.
  - drop = PREV - ADC_IN when PREV_VALID and PREV > ADC_IN; otherwise drop = 0. drop is ADC_W bits.
  - rate_trip = in_window and drop > zero-extended RATE_LIMIT. A drop exactly equal to RATE_LIMIT does not trip.
  - Rises and drops that occur while ADC_IN >= BOD_THRESH1 never trip.
  - PREV <= ADC_IN and PREV_VALID <= 1 on every edge.
- Rate checking is disabled on the first sample after reset, because PREV_VALID=0 at that edge.
- Assert:
  - If hard_trip or rate_trip, BROWNOUT <= 1 at that edge and the release counter <= 0.
  - Latency is one edge: BROWNOUT is visible after the edge that sampled the offending value.
- Hold:
  - While BROWNOUT=1 and BOD_THRESH2 <= ADC_IN < BOD_THRESH1 with no rate_trip, BROWNOUT stays 1 and the counter <= 0.
- Release:
  - While BROWNOUT=1 and ADC_IN >= BOD_THRESH1, the counter increments.
  - On the edge where the counter would reach RELEASE_CNT, BROWNOUT <= 0 and the counter <= 0.
  - Any sample below BOD_THRESH1 clears the counter.
  - The counter saturates and cannot wrap; its width is clog2(RELEASE_CNT+1).
- Idle:
  - While BROWNOUT=0 and there is no trip, BROWNOUT stays 0.
  - Window samples with drop <= RATE_LIMIT do not assert.
- Simultaneous hard_trip and rate_trip behave as a single assert.
- A trip always wins over release.
- Misconfiguration (BOD_THRESH2 >= BOD_THRESH1):
  - hard_trip still applies.
  - No special handling is required.
- Threshold and RATE_LIMIT changes take effect on the next edge; they are not latched.
- Reset mid-operation forces BROWNOUT=0 immediately, regardless of CLK.
- No X propagation handling is required beyond reset.
  - Implementations must not depend on ADC_IN during reset.

Test Plan:
All scenarios use BOD_THRESH1=E38E4, BOD_THRESH2=D5555, RATE_LIMIT=00C, RELEASE_CNT=4.
1. Reset and healthy input:
   - Assert RST_N=0 mid-cycle -> BROWNOUT=0 immediately.
   - Release reset, then drive FFFF0 followed by F0000 (drop FFF0, above window) -> BROWNOUT stays 0.
2. Slow in-window decline:
   - Drive E38E4, E38E3, E38E0 (drops 1 and 3) -> BROWNOUT=0.
   - Then drive E38A4 (drop 3C > C) -> BROWNOUT=1 after that edge.
3. Rate boundary:
   - From PREV=E3800, drive E37F4 (drop exactly C) -> no assert.
   - From PREV=E3800, drive E37F3 (drop D) -> assert.
   - A drop of 20 at ADC=E3900 (>= THRESH1) -> no assert.
4. Hard threshold boundary, with steps of 1 and RATE_LIMIT=FFF so rate never trips:
   - ADC=D5555 -> BROWNOUT stays 0.
   - ADC=D5554 -> BROWNOUT=1 on that edge.
5. Release hysteresis:
   - While tripped, drive E38E4 for 3 samples -> BROWNOUT remains 1.
   - 4th sample -> BROWNOUT=0.
   - Repeat with E38E3 inserted after 2 healthy samples -> the counter restarts, and 4 further healthy samples are needed.
6. First-sample and mid-operation reset:
   - Immediately after reset, drive E38E0 -> BROWNOUT=0 (no PREV).
   - Assert RST_N while BROWNOUT=1 -> BROWNOUT=0 immediately, and the next sample E3800 does not rate-trip.
